matproc_job_scheduler: RTL and testbench
========================================

Name: matproc_job_scheduler

Overview:
- Queues transform jobs from the command front end and issues them one at a time to the matrix processor.
- A job is a matrix address, a vertex input address, a vertex output address and a work-item count.
- The block drives the processor's start/address/count inputs, tracks its busy signal, and signals completion for each job.
- It sits between the command/AXI-lite register interface and a single matrix processor instance.

Parameters:
- WIDTH, 32, address width; matches the processor's WIDTH.
- DEPTH, 4, job queue entries; power of 2, minimum 2.
- CNT_W, 14, work-item count width; matches the processor's workItemCount.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- job_valid  input  1  job presented
- job_ready  output  1  queue can accept a job; equals !full
- job_matrix_addr  input  WIDTH  matrix base address
- job_in_addr  input  WIDTH  vertex input base address
- job_out_addr  input  WIDTH  vertex output base address
- job_count  input  CNT_W  work-item count
- mp_start  output  1  one-cycle start pulse to the processor
- mp_matrix_addr  output  WIDTH  registered; held stable from ISSUE until the next issue
- mp_in_addr  output  WIDTH  registered; held as above
- mp_out_addr  output  WIDTH  registered; held as above
- mp_count  output  CNT_W  registered; held as above
- mp_busy  input  1  processor is non-IDLE
- job_done  output  1  one-cycle pulse per retired job
- jobs_completed  output  16  count of retired jobs; wraps
- queue_level  output  $clog2(DEPTH)+1  number of occupied queue entries
- idle  output  1  queue empty, state IDLE and mp_busy low

Behaviour:
- Reset (async assert, sync release), all values 0:
  - state=IDLE; queue empty; job_ready=1.
  - mp_start, mp_* registers, job_done, jobs_completed, queue_level all 0.
  - idle=1 if mp_busy=0.
- Queue:
  - Push on job_valid && job_ready.
  - Pop only in IDLE when not empty.
  - Simultaneous push and pop is allowed; queue_level is unchanged.
  - A push while full is impossible (job_ready=0); job_valid while full is ignored.
  - Pointers wrap modulo DEPTH.
  - A push into an empty queue is visible to the FSM the next cycle (no bypass).
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE:
  - If queue not empty: pop the head into the mp_* registers.
  - If head count != 0, go to ISSUE.
  - If head count == 0: retire immediately (job_done=1 next cycle, jobs_completed+1), stay IDLE, no mp_start.
- ISSUE:
  - mp_start=1 for exactly this cycle; go to WAIT_ACK.
- WAIT_ACK:
  - Wait for mp_busy=1, then go to WAIT_DONE.
  - mp_busy already high on entry is accepted immediately.
- WAIT_DONE:
  - On mp_busy=0: job_done pulses for one cycle, jobs_completed increments, go to IDLE.
- Issue latency:
  - Job pushed at edge T into an empty, idle block: pop at T+1, ISSUE at T+1..T+2, mp_start high in the cycle after edge T+1.
  - Minimum gap between consecutive mp_start pulses is 4 cycles.
- mp_* registers change only on a pop, so they stay stable through the whole processor run.
- jobs_completed wraps 0xFFFF -> 0x0000 without stalling.
- mp_busy glitches in IDLE/ISSUE are ignored.
- Reset mid-operation: queue contents discarded, outputs cleared. The processor is reset by the same rst domain; no in-flight completion is reported.

Test Plan:
- Reset, then a single job (matrix 0x1000, in 0x2000, out 0x3000, count 5); processor model holds busy for 20 cycles -> one mp_start with the exact mp_* values, one job_done, jobs_completed=1, idle=1 at end.
- Push 5 jobs back-to-back with DEPTH=4 while the processor is busy -> job_ready drops after the 4th entry is occupied; all 5 jobs issue in FIFO order with the correct addresses; jobs_completed=5.
- Job with count 0 between two count-3 jobs -> no mp_start for it; job_done pulses three times; mp_start pulses twice.
- Processor model asserts busy 3 cycles after start -> FSM holds in WAIT_ACK; no early job_done; mp_* stable throughout.
- Assert rst mid WAIT_DONE with 2 jobs queued -> queue_level=0, no job_done, mp_start=0; a new job after release issues normally.
- Preload jobs_completed to 0xFFFF via 65535 count-0 jobs (or force), then one more -> jobs_completed=0x0000 and job_done pulses once.

Source files
------------

// File: rtl/matproc_job_scheduler.sv
// matproc_job_scheduler: queues transform jobs and issues them one at a time to the matrix processor,
// tracking its busy signal and reporting each retired job.
module matproc_job_scheduler #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [WIDTH-1:0]        job_matrix_addr,
  input  logic [WIDTH-1:0]        job_in_addr,
  input  logic [WIDTH-1:0]        job_out_addr,
  input  logic [CNT_W-1:0]        job_count,
  output logic                    mp_start,
  output logic [WIDTH-1:0]        mp_matrix_addr,
  output logic [WIDTH-1:0]        mp_in_addr,
  output logic [WIDTH-1:0]        mp_out_addr,
  output logic [CNT_W-1:0]        mp_count,
  input  logic                    mp_busy,
  output logic                    job_done,
  output logic [15:0]             jobs_completed,
  output logic [$clog2(DEPTH):0]  queue_level,
  output logic                    idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int JW = 3 * WIDTH + CNT_W;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
  state_t r_state, w_next;
  logic [JW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_level;
  logic [WIDTH-1:0] r_matrix_addr, r_in_addr, r_out_addr;
  logic [CNT_W-1:0] r_count;
  logic r_job_done;
  logic [15:0] r_jobs_completed;
  logic [JW-1:0] w_head;
  logic w_push, w_pop, w_retire;
  assign job_ready = r_level != (AW+1)'(DEPTH);
  assign w_push = job_valid && job_ready;
  assign w_head = r_mem[r_rptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // A zero-count job retires straight out of IDLE without ever starting the processor.
  always_comb begin
    w_next = r_state;
    w_pop = 1'b0;
    w_retire = 1'b0;
    mp_start = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop = r_level != '0;
        w_retire = w_pop && w_head[CNT_W-1:0] == '0;
        w_next = (w_pop && !w_retire) ? ISSUE : IDLE;
      end
      ISSUE: begin
        mp_start = 1'b1;
        w_next = WAIT_ACK;
      end
      WAIT_ACK: w_next = mp_busy ? WAIT_DONE : WAIT_ACK;
      WAIT_DONE: begin
        w_retire = !mp_busy;
        w_next = mp_busy ? WAIT_DONE : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {job_matrix_addr, job_in_addr, job_out_addr, job_count};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_level <= '0;
    end else begin
      r_wptr <= w_push ? r_wptr + AW'(1) : r_wptr;
      r_rptr <= w_pop ? r_rptr + AW'(1) : r_rptr;
      r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end
  // Processor-facing registers only change on a pop, so they hold for the whole run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_matrix_addr, r_in_addr, r_out_addr, r_count} <= '0;
      r_job_done <= 1'b0;
      r_jobs_completed <= '0;
    end else begin
      if (w_pop) {r_matrix_addr, r_in_addr, r_out_addr, r_count} <= w_head;
      r_job_done <= w_retire;
      r_jobs_completed <= w_retire ? r_jobs_completed + 16'd1 : r_jobs_completed;
    end
  end
  assign mp_matrix_addr = r_matrix_addr;
  assign mp_in_addr = r_in_addr;
  assign mp_out_addr = r_out_addr;
  assign mp_count = r_count;
  assign job_done = r_job_done;
  assign jobs_completed = r_jobs_completed;
  assign queue_level = r_level;
  assign idle = r_level == '0 && r_state == IDLE && !mp_busy;
endmodule

// File: tb/tb_matproc_job_scheduler.sv
// tb_matproc_job_scheduler: directed vectors against a small processor model that raises busy
// a programmable delay after each start and holds it for a programmable run length.
module tb_matproc_job_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic job_valid = 1'b0;
  logic job_ready;
  logic [31:0] job_matrix_addr = '0, job_in_addr = '0, job_out_addr = '0;
  logic [13:0] job_count = '0;
  logic mp_start;
  logic [31:0] mp_matrix_addr, mp_in_addr, mp_out_addr;
  logic [13:0] mp_count;
  logic mp_busy = 1'b0;
  logic job_done;
  logic [15:0] jobs_completed;
  logic [2:0] queue_level;
  logic idle;

  matproc_job_scheduler #(.WIDTH(32), .DEPTH(4), .CNT_W(14)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_matrix_addr(job_matrix_addr), .job_in_addr(job_in_addr),
    .job_out_addr(job_out_addr), .job_count(job_count),
    .mp_start(mp_start), .mp_matrix_addr(mp_matrix_addr), .mp_in_addr(mp_in_addr),
    .mp_out_addr(mp_out_addr), .mp_count(mp_count), .mp_busy(mp_busy),
    .job_done(job_done), .jobs_completed(jobs_completed),
    .queue_level(queue_level), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] m, i, o;
    logic [13:0] c;
    logic [2:0]  lvl;
    logic        rdy;
  } vec_t;
  vec_t tbl [5];

  int n_cmp = 0, n_bad = 0;
  int n_start = 0, n_done = 0;
  int ack_dly = 1, run_len = 20, w_cnt = 0, r_cnt = 0;
  logic [31:0] iss_m [$], iss_i [$], iss_o [$];
  logic [13:0] iss_c [$];

  // Processor model: busy rises ack_dly cycles after start and stays high run_len cycles.
  always @(negedge clk) begin
    if (rst) begin
      mp_busy = 1'b0;
      w_cnt = 0;
      r_cnt = 0;
    end else if (mp_busy) begin
      r_cnt--;
      if (r_cnt == 0) mp_busy = 1'b0;
    end else if (w_cnt > 0) begin
      w_cnt--;
      if (w_cnt == 0) begin
        mp_busy = 1'b1;
        r_cnt = run_len;
      end
    end
    if (!rst && mp_start) w_cnt = ack_dly;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mp_start) begin
        n_start++;
        iss_m.push_back(mp_matrix_addr);
        iss_i.push_back(mp_in_addr);
        iss_o.push_back(mp_out_addr);
        iss_c.push_back(mp_count);
      end
      if (job_done) n_done++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  task automatic chk_iss(input string nm, input int idx, input logic [31:0] m, i, o, input logic [13:0] c);
    if (idx >= iss_m.size()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: issue #%0d missing, only %0d issued", nm, idx, iss_m.size());
    end else begin
      chk({nm, " matrix"}, iss_m[idx], m);
      chk({nm, " in"}, iss_i[idx], i);
      chk({nm, " out"}, iss_o[idx], o);
      chk({nm, " count"}, iss_c[idx], c);
    end
  endtask

  // Called just after a negedge; returns at the negedge following the accepting posedge.
  task automatic push(input logic [31:0] m, i, o, input logic [13:0] c);
    int k = 0;
    job_matrix_addr = m;
    job_in_addr = i;
    job_out_addr = o;
    job_count = c;
    job_valid = 1'b1;
    while (!job_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!job_ready) chk("push ready timeout", job_ready, 1);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    @(negedge clk);
    while (!idle && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " idle"}, idle, 1);
    @(negedge clk);
  endtask

  initial begin
    int b, s0, d0, d1;
    tbl[0] = '{32'h1100, 32'h2100, 32'h3100, 14'd4, 3'd1, 1'b1};
    tbl[1] = '{32'h1200, 32'h2200, 32'h3200, 14'd3, 3'd1, 1'b1};
    tbl[2] = '{32'h1300, 32'h2300, 32'h3300, 14'd2, 3'd2, 1'b1};
    tbl[3] = '{32'h1400, 32'h2400, 32'h3400, 14'd6, 3'd3, 1'b1};
    tbl[4] = '{32'h1500, 32'h2500, 32'h3500, 14'd1, 3'd4, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst job_ready", job_ready, 1);
    chk("rst mp_start", mp_start, 0);
    chk("rst mp_matrix", mp_matrix_addr, 0);
    chk("rst mp_count", mp_count, 0);
    chk("rst job_done", job_done, 0);
    chk("rst completed", jobs_completed, 0);
    chk("rst level", queue_level, 0);
    chk("rst idle", idle, 1);
    rst = 1'b0;
    @(negedge clk);

    // Single job: issue latency and exact processor-facing values.
    run_len = 20;
    b = iss_m.size();
    push(32'h1000, 32'h2000, 32'h3000, 14'd5);
    chk("t1 level after push", queue_level, 1);
    chk("t1 no early start", mp_start, 0);
    @(negedge clk);
    chk("t1 start", mp_start, 1);
    chk("t1 mp_matrix", mp_matrix_addr, 32'h1000);
    chk("t1 mp_count", mp_count, 5);
    chk("t1 level after pop", queue_level, 0);
    wait_idle("t1");
    chk("t1 starts", n_start, 1);
    chk("t1 dones", n_done, 1);
    chk("t1 completed", jobs_completed, 1);
    chk_iss("t1 issue", b, 32'h1000, 32'h2000, 32'h3000, 14'd5);

    // Five back-to-back jobs against a busy processor: fill to full, FIFO order.
    run_len = 10;
    b = iss_m.size();
    s0 = n_start;
    d0 = n_done;
    for (int v = 0; v < 5; v++) begin
      push(tbl[v].m, tbl[v].i, tbl[v].o, tbl[v].c);
      chk($sformatf("t2 level v%0d", v), queue_level, tbl[v].lvl);
      chk($sformatf("t2 ready v%0d", v), job_ready, tbl[v].rdy);
    end
    job_matrix_addr = 32'hDEAD;
    job_count = 14'd9;
    job_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("t2 full ignores valid", queue_level, 4);
    job_valid = 1'b0;
    wait_idle("t2");
    for (int v = 0; v < 5; v++) chk_iss($sformatf("t2 issue v%0d", v), b + v, tbl[v].m, tbl[v].i, tbl[v].o, tbl[v].c);
    chk("t2 starts", n_start - s0, 5);
    chk("t2 dones", n_done - d0, 5);
    chk("t2 completed", jobs_completed, 6);

    // Zero-count job between two real jobs.
    run_len = 5;
    b = iss_m.size();
    s0 = n_start;
    d0 = n_done;
    push(32'hA000, 32'hA100, 32'hA200, 14'd3);
    push(32'hB000, 32'hB100, 32'hB200, 14'd0);
    push(32'hC000, 32'hC100, 32'hC200, 14'd3);
    wait_idle("t3");
    chk("t3 starts", n_start - s0, 2);
    chk("t3 dones", n_done - d0, 3);
    chk("t3 completed", jobs_completed, 9);
    chk_iss("t3 first", b, 32'hA000, 32'hA100, 32'hA200, 14'd3);
    chk_iss("t3 second", b + 1, 32'hC000, 32'hC100, 32'hC200, 14'd3);

    // Slow acknowledge: must hold in WAIT_ACK with stable registers.
    ack_dly = 3;
    d0 = n_done;
    push(32'h4400, 32'h5500, 32'h6600, 14'd7);
    @(negedge clk);
    chk("t4 start", mp_start, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("t4 no restart c%0d", k), mp_start, 0);
      chk($sformatf("t4 no early done c%0d", k), job_done, 0);
      chk($sformatf("t4 mp_matrix c%0d", k), mp_matrix_addr, 32'h4400);
      chk($sformatf("t4 mp_count c%0d", k), mp_count, 7);
    end
    wait_idle("t4");
    chk("t4 dones", n_done - d0, 1);
    chk("t4 completed", jobs_completed, 10);
    chk("t4 mp_in held", mp_in_addr, 32'h5500);
    ack_dly = 1;

    // Reset in WAIT_DONE with two jobs queued.
    run_len = 30;
    push(32'h7000, 32'h7100, 32'h7200, 14'd2);
    push(32'h7300, 32'h7400, 32'h7500, 14'd2);
    push(32'h7600, 32'h7700, 32'h7800, 14'd2);
    chk("t5 level before rst", queue_level, 2);
    repeat (4) @(negedge clk);
    d0 = n_done;
    rst = 1'b1;
    #1;
    chk("t5 rst level", queue_level, 0);
    chk("t5 rst start", mp_start, 0);
    chk("t5 rst done", job_done, 0);
    chk("t5 rst completed", jobs_completed, 0);
    chk("t5 rst mp_matrix", mp_matrix_addr, 0);
    chk("t5 rst ready", job_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5 no stale done", n_done - d0, 0);
    chk("t5 idle after rst", idle, 1);
    run_len = 5;
    b = iss_m.size();
    push(32'h8000, 32'h8100, 32'h8200, 14'd1);
    wait_idle("t5");
    chk_iss("t5 new job", b, 32'h8000, 32'h8100, 32'h8200, 14'd1);
    chk("t5 completed", jobs_completed, 1);

    // Counter wrap via count-0 jobs.
    s0 = n_start;
    d0 = n_done;
    for (int k = 0; k < 65534; k++) push(32'(k), 32'(k), 32'(k), 14'd0);
    repeat (3) @(negedge clk);
    chk("t6 completed max", jobs_completed, 16'hFFFF);
    chk("t6 dones", n_done - d0, 65534);
    d1 = n_done;
    push(32'hF000, 32'hF100, 32'hF200, 14'd0);
    repeat (3) @(negedge clk);
    chk("t6 completed wrap", jobs_completed, 0);
    chk("t6 wrap done once", n_done - d1, 1);
    chk("t6 no starts", n_start - s0, 0);
    chk("t6 idle", idle, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
